seq_detect_moore_param: RTL and testbench

Parametrised Moore-type serial pattern detector. It watches a 1-bit serial stream qualified by a valid strobe and detects a PAT_W-bit pattern that can be loaded at run time. Overlapping or non-overlapping detection is selected per cycle. It also keeps a saturating match counter. It sits beside the other serial front-end FSMs and drives one-cycle match pulses to downstream control.

---
 rtl/seq_detect_pkg.sv | 13 +
 rtl/seq_detect_moore_param_sat_counter.sv | 31 +++
 rtl/seq_detect_moore_param.sv | 107 ++++++++++
 tb/tb_seq_detect_moore_param.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types for the serial pattern detector: FSM state encoding and the
// default pattern width.
package seq_detect_pkg;

  localparam int DEFAULT_PAT_W = 4;

  typedef enum logic [1:0] {
    FILL  = 2'b00,
    ARMED = 2'b01,
    HIT   = 2'b10
  } state_t;

endpackage

// File: rtl/seq_detect_moore_param_sat_counter.sv
// Saturating up-counter used for the detector's match count; sat flags the
// all-ones value.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r;

  // Count register: advance on inc, stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;
  assign sat = (cnt_r == CNT_MAX);

endmodule

// File: rtl/seq_detect_moore_param.sv
// Moore serial pattern detector with run-time loadable pattern and selectable
// overlap. Define MATCH_CNT_EN to build the saturating match counter.
module seq_detect_moore_param
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W       = DEFAULT_PAT_W,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(4'b1011),
  parameter int               CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int             FW       = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_W);

  state_t           state_r, state_s;
  logic [PAT_W-1:0] hist_r, hist_s, base_hist_s;
  logic [FW-1:0]    fill_r, fill_s, base_fill_s;
  logic [PAT_W-1:0] pat_r, pat_s;
  logic             restart_s;
  logic             out_s;

  // State, history, fill count and pattern registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FILL;
      hist_r  <= {PAT_W{1'b0}};
      fill_r  <= {FW{1'b0}};
      pat_r   <= DEFAULT_PAT;
    end else begin
      state_r <= state_s;
      hist_r  <= hist_s;
      fill_r  <= fill_s;
      pat_r   <= pat_s;
    end
  end

  // Next-state logic. Leaving HIT without overlap wipes the history first, so a
  // bit arriving that same cycle starts the new history.
  always_comb begin
    restart_s   = (state_r == HIT) && !overlap;
    base_hist_s = restart_s ? {PAT_W{1'b0}} : hist_r;
    base_fill_s = restart_s ? {FW{1'b0}} : fill_r;
    state_s     = state_r;
    hist_s      = base_hist_s;
    fill_s      = base_fill_s;
    pat_s       = pat_r;
    if (pat_load) begin
      pat_s   = pat_in;
      hist_s  = {PAT_W{1'b0}};
      fill_s  = {FW{1'b0}};
      state_s = FILL;
    end else if (in_valid) begin
      hist_s = {base_hist_s[PAT_W-2:0], in};
      fill_s = (base_fill_s == FILL_MAX) ? FILL_MAX : base_fill_s + FW'(1);
      if ((fill_s == FILL_MAX) && (hist_s == pat_r)) begin
        state_s = HIT;
      end else if (fill_s == FILL_MAX) begin
        state_s = ARMED;
      end else begin
        state_s = FILL;
      end
    end else begin
      case (state_r)
        FILL:    state_s = FILL;
        ARMED:   state_s = ARMED;
        HIT:     state_s = overlap ? ARMED : FILL;
        default: state_s = FILL;
      endcase
    end
  end

  // Moore output: decode of the state register only.
  always_comb begin
    out_s = (state_r == HIT);
  end

  assign out = out_s;

`ifdef MATCH_CNT_EN
  logic cnt_inc_s;
  assign cnt_inc_s = (state_s == HIT);

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(cnt_inc_s),
    .cnt(match_cnt),
    .sat(cnt_sat)
  );
`else
  assign match_cnt = {CNT_W{1'b0}};
  assign cnt_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// Bench for seq_detect_moore_param: directed scenarios plus random traffic,
// checked against a queue-based model of the detection rules.
module tb_seq_detect_moore_param;

  localparam int PAT_W   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in;
  logic             in_valid;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             overlap;
  logic             out;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  seq_detect_moore_param #(
    .PAT_W(PAT_W),
    .DEFAULT_PAT(4'b1011),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in(in),
    .in_valid(in_valid),
    .pat_load(pat_load),
    .pat_in(pat_in),
    .overlap(overlap),
    .out(out),
    .match_cnt(match_cnt),
    .cnt_sat(cnt_sat)
  );

  always #5 clk = ~clk;

  // Reference model: valid bits since the last restart, current pattern,
  // whether the last edge produced a hit, and the saturating hit count.
  bit               bits_q[$];
  logic [PAT_W-1:0] m_pat;
  logic             m_hit;
  int               m_cnt;
  int               checks = 0;
  int               passed = 0;
  int               fails  = 0;

  function automatic logic tail_matches();
    logic [PAT_W-1:0] v;
    if (bits_q.size() < PAT_W) return 1'b0;
    v = '0;
    for (int i = 0; i < PAT_W; i++) v = {v[PAT_W-2:0], logic'(bits_q[bits_q.size() - PAT_W + i])};
    return v == m_pat;
  endfunction

  task automatic model_reset();
    bits_q.delete();
    m_pat = 4'b1011;
    m_hit = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_step();
    if (pat_load) begin
      m_pat = pat_in;
      bits_q.delete();
      m_hit = 1'b0;
    end else begin
      if (m_hit && !overlap) bits_q.delete();
      if (in_valid) begin
        bits_q.push_back(in);
        if (bits_q.size() > PAT_W) void'(bits_q.pop_front());
        m_hit = tail_matches();
      end else begin
        m_hit = 1'b0;
      end
    end
`ifdef MATCH_CNT_EN
    if (m_hit && m_cnt < CNT_MAX) m_cnt++;
`endif
  endtask

  task automatic check(input string tag);
    checks++;
    assert (out === m_hit) passed++;
    else begin fails++; $error("FAIL %s out: got %0b want %0b", tag, out, m_hit); end
    checks++;
    assert (match_cnt === CNT_W'(m_cnt)) passed++;
    else begin fails++; $error("FAIL %s match_cnt: got %0d want %0d", tag, match_cnt, m_cnt); end
    checks++;
    assert (cnt_sat === (m_cnt == CNT_MAX)) passed++;
    else begin fails++; $error("FAIL %s cnt_sat: got %0b want %0b", tag, cnt_sat, (m_cnt == CNT_MAX)); end
  endtask

  task automatic step(input logic v, input logic b, input string tag);
    in_valid = v;
    in       = b;
    pat_load = 1'b0;
    @(posedge clk);
    #1;
    model_step();
    check(tag);
  endtask

  task automatic load(input logic [PAT_W-1:0] p, input logic v, input logic b, input string tag);
    pat_load = 1'b1;
    pat_in   = p;
    in_valid = v;
    in       = b;
    @(posedge clk);
    #1;
    model_step();
    check(tag);
    pat_load = 1'b0;
    in_valid = 1'b0;
  endtask

  logic [6:0] s1;

  initial begin
    s1       = 7'b1011011;
    rst      = 1'b1;
    in       = 1'b0;
    in_valid = 1'b0;
    pat_load = 1'b0;
    pat_in   = '0;
    overlap  = 1'b1;
    model_reset();
    #12;
    check("reset");
    @(negedge clk);
    rst = 1'b0;

    // Plan 1: overlap on, hits after bits 4 and 7.
    for (int i = 6; i >= 0; i--) step(1'b1, s1[i], "ovl_stream");
    step(1'b0, 1'b0, "ovl_idle");

    // Plan 2: overlap off, hit after bit 4 only.
    overlap = 1'b0;
    load(4'b1011, 1'b0, 1'b0, "reload_1011");
    for (int i = 6; i >= 0; i--) step(1'b1, s1[i], "novl_stream");
    step(1'b0, 1'b0, "novl_idle");

    // Plan 3: pattern 1111, overlap on, consecutive hits.
    overlap = 1'b1;
    load(4'b1111, 1'b0, 1'b0, "load_1111");
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, "ones");
    step(1'b0, 1'b0, "ones_idle");

    // Plan 4: gaps between valid bits, one-cycle pulse.
    load(4'b1011, 1'b0, 1'b0, "load_gap");
    step(1'b1, 1'b1, "gap_b1");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "gap_idle1");
    step(1'b1, 1'b0, "gap_b2");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "gap_idle2");
    step(1'b1, 1'b1, "gap_b3");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "gap_idle3");
    step(1'b1, 1'b1, "gap_b4");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "gap_after");

    // Plan 5: pat_load wins over the completing bit.
    step(1'b1, 1'b1, "pl_b1");
    step(1'b1, 1'b0, "pl_b2");
    step(1'b1, 1'b1, "pl_b3");
    load(4'b0110, 1'b1, 1'b1, "pl_collide");
    step(1'b1, 1'b0, "pl_new0");
    step(1'b1, 1'b1, "pl_new1");
    step(1'b1, 1'b1, "pl_new2");
    step(1'b1, 1'b0, "pl_new3");
    step(1'b0, 1'b0, "pl_idle");

    // Plan 6: async reset mid-stream, then default pattern again.
    step(1'b1, 1'b1, "pre_rst0");
    step(1'b1, 1'b1, "pre_rst1");
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 6; i >= 3; i--) step(1'b1, s1[i], "post_rst");

    // Random traffic with occasional pattern reloads.
    for (int n = 0; n < 400; n++) begin
      overlap = logic'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0)
        load(PAT_W'($urandom_range(0, (1 << PAT_W) - 1)), logic'($urandom_range(0, 1)),
             logic'($urandom_range(0, 1)), "rnd_load");
      else
        step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)), "rnd");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
